dma_chan_ctrl: RTL and testbench

DMA_CHAN_CTRL -- requirements
Module: dma_chan_ctrl

---
 rtl/dma_chan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dma_chan_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_chan_ctrl.sv
// dma_chan_ctrl: per-channel descriptor FSMs feeding a shared round-robin command port.
// Optional macro DMA_4K_SPLIT_EN keeps every command inside one 4KB page.
module dma_chan_ctrl #(
    parameter int N_CH             = 4,
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_DATA_WIDTH   = 32,
    parameter int TOP_LEN_WIDTH    = 32,
    parameter int MAX_BURST        = 64,
    parameter int CONFIG_LEN_WIDTH = 9,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_CH-1:0]                  desc_valid,
    output logic [N_CH-1:0]                  desc_ready,
    input  logic [N_CH-1:0]                  desc_write,
    input  logic [N_CH*TOP_LEN_WIDTH-1:0]    desc_len,
    input  logic [N_CH*AXI_ADDR_WIDTH-1:0]   desc_addr,
    output logic [N_CH-1:0]                  ch_busy,
    output logic [N_CH-1:0]                  ch_done,
    output logic                             cmd_valid,
    input  logic                             cmd_ready,
    output logic [CONFIG_LEN_WIDTH-1:0]      cmd_len,
    output logic [AXI_ADDR_WIDTH-1:0]        cmd_addr,
    output logic                             cmd_write,
    output logic [CH_W-1:0]                  cmd_ch,
    input  logic                             rd_empty,
    input  logic                             wr_empty
);

    localparam int RATE    = AXI_DATA_WIDTH / 8;
    localparam int RATE_SH = $clog2(RATE);
    localparam logic [TOP_LEN_WIDTH-1:0] MAXB = TOP_LEN_WIDTH'(MAX_BURST);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                    st      [N_CH];
    logic [AXI_ADDR_WIDTH-1:0] ch_addr [N_CH];
    logic [TOP_LEN_WIDTH-1:0]  ch_len  [N_CH];
    logic [N_CH-1:0]           ch_wr;
    logic [N_CH-1:0]           done_q;
    logic [N_CH-1:0]           req;

    logic [CH_W-1:0]           rr_ptr;
    logic [CH_W-1:0]           hold_ch;
    logic                      hold_vld;
    logic [CH_W-1:0]           gnt;
    logic [CH_W-1:0]           cand;
    logic                      found;
    logic                      hs;

    logic [AXI_ADDR_WIDTH-1:0] sel_addr;
    logic [TOP_LEN_WIDTH-1:0]  sel_len;
    logic [TOP_LEN_WIDTH-1:0]  chunk;
    logic [AXI_ADDR_WIDTH-1:0] next_addr;
`ifdef DMA_4K_SPLIT_EN
    logic [12:0]               room;
    logic [TOP_LEN_WIDTH-1:0]  bnd;
`endif

    // Per-channel status decoded from the state registers
    always_comb begin
        req        = '0;
        ch_busy    = '0;
        desc_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            req[i]        = (st[i] == ISSUE);
            ch_busy[i]    = (st[i] != IDLE);
            desc_ready[i] = (st[i] == IDLE);
        end
    end

    // Round-robin pick from rr_ptr; a stalled grant stays locked until accepted
    always_comb begin
        gnt   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            cand = CH_W'((int'(rr_ptr) + k) % N_CH);
            if (!found && req[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
        if (hold_vld) begin
            gnt = hold_ch;
        end
    end

    // Chunk size of the granted channel and its post-issue address
    always_comb begin
        sel_addr = ch_addr[gnt];
        sel_len  = ch_len[gnt];
        chunk    = (sel_len < MAXB) ? sel_len : MAXB;
`ifdef DMA_4K_SPLIT_EN
        room = 13'h1000 - {1'b0, sel_addr[11:0]};
        bnd  = TOP_LEN_WIDTH'(room >> RATE_SH);
        if (bnd < chunk) begin
            chunk = bnd;
        end
`endif
        next_addr = sel_addr + (AXI_ADDR_WIDTH'(chunk) << RATE_SH);
    end

    assign cmd_valid = |req;
    assign hs        = cmd_valid & cmd_ready;
    assign cmd_addr  = sel_addr;
    assign cmd_len   = CONFIG_LEN_WIDTH'(chunk);
    assign cmd_write = ch_wr[gnt];
    assign cmd_ch    = gnt;
    assign ch_done   = done_q;

    // Channel FSMs: accept descriptor, issue chunks, drain, signal completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                st[i]      <= IDLE;
                ch_addr[i] <= '0;
                ch_len[i]  <= '0;
            end
            ch_wr  <= '0;
            done_q <= '0;
        end else begin
            done_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                unique case (st[i])
                    IDLE: begin
                        if (desc_valid[i]) begin
                            ch_addr[i] <= desc_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                            ch_len[i]  <= desc_len[i*TOP_LEN_WIDTH +: TOP_LEN_WIDTH];
                            ch_wr[i]   <= desc_write[i];
                            if (desc_len[i*TOP_LEN_WIDTH +: TOP_LEN_WIDTH] == '0) begin
                                done_q[i] <= 1'b1;
                            end else begin
                                st[i] <= ISSUE;
                            end
                        end
                    end
                    ISSUE: begin
                        if (hs && gnt == CH_W'(i)) begin
                            ch_addr[i] <= next_addr;
                            ch_len[i]  <= sel_len - chunk;
                            if (sel_len == chunk) begin
                                st[i] <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (ch_wr[i] ? wr_empty : rd_empty) begin
                            st[i]     <= IDLE;
                            done_q[i] <= 1'b1;
                        end
                    end
                    default: st[i] <= IDLE;
                endcase
            end
        end
    end

    // Arbiter state: priority pointer and stalled-grant lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            hold_vld <= 1'b0;
            hold_ch  <= '0;
        end else begin
            hold_vld <= cmd_valid & ~cmd_ready;
            hold_ch  <= gnt;
            if (hs) begin
                rr_ptr <= (gnt == LAST_CH) ? '0 : gnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_chan_ctrl.sv
// tb_dma_chan_ctrl: directed and random stimulus checked against a
// descriptor-splitting reference model (honours DMA_4K_SPLIT_EN).
module tb_dma_chan_ctrl;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 32;
    localparam int CW = 9;
    localparam int MB = 64;
    localparam int RT = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    desc_valid;
    logic [N-1:0]    desc_ready;
    logic [N-1:0]    desc_write;
    logic [N*LW-1:0] desc_len;
    logic [N*AW-1:0] desc_addr;
    logic [N-1:0]    ch_busy;
    logic [N-1:0]    ch_done;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [CW-1:0]   cmd_len;
    logic [AW-1:0]   cmd_addr;
    logic            cmd_write;
    logic [1:0]      cmd_ch;
    logic            rd_empty;
    logic            wr_empty;

    always #5 clk = ~clk;

    dma_chan_ctrl #(
        .N_CH(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(32),
        .TOP_LEN_WIDTH(LW), .MAX_BURST(MB), .CONFIG_LEN_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_write(desc_write), .desc_len(desc_len), .desc_addr(desc_addr),
        .ch_busy(ch_busy), .ch_done(ch_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_ch(cmd_ch),
        .rd_empty(rd_empty), .wr_empty(wr_empty)
    );

    // reference model: per-channel list of expected commands
    logic [31:0] qa [N][64];
    int          qn [N][64];
    int          qh [N];
    int          qt [N];
    bit          m_wr [N];
    bit          m_drain [N];
    bit          m_done [N];
    int          m_ptr;
    bit          m_hold;
    int          m_hold_ch;

    int n_chk;
    int n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int c = 0; c < N; c++) begin
            qh[c] = 0; qt[c] = 0;
            m_wr[c] = 0; m_drain[c] = 0; m_done[c] = 0;
        end
        m_ptr = 0;
        m_hold = 0;
        m_hold_ch = 0;
    endfunction

    function automatic bit pend(int c);
        return qh[c] < qt[c];
    endfunction

    function automatic bit busy(int c);
        return pend(c) || m_drain[c];
    endfunction

    function automatic void load(int c, logic [31:0] a, int len, bit w);
        int n;
`ifdef DMA_4K_SPLIT_EN
        int room;
`endif
        qh[c] = 0; qt[c] = 0; m_wr[c] = w;
        if (len == 0) m_done[c] = 1;
        while (len > 0) begin
            n = (len < MB) ? len : MB;
`ifdef DMA_4K_SPLIT_EN
            room = (4096 - int'(a[11:0])) / RT;
            if (room < n) n = room;
`endif
            qa[c][qt[c]] = a;
            qn[c][qt[c]] = n;
            qt[c]++;
            a = a + 32'(n * RT);
            len -= n;
        end
    endfunction

    function automatic int exp_gnt();
        int j;
        if (m_hold) return m_hold_ch;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (pend(j)) return j;
        end
        return -1;
    endfunction

    task automatic step();
        int g;
        logic [N-1:0] eb;
        logic [N-1:0] er;
        logic [N-1:0] ed;
        #1;
        if (!rst_n) m_reset();
        g = exp_gnt();
        for (int c = 0; c < N; c++) begin
            eb[c] = busy(c);
            ed[c] = m_done[c];
        end
        er = ~eb;
        chk("ch_busy", ch_busy, eb);
        chk("desc_ready", desc_ready, er);
        chk("ch_done", ch_done, ed);
        chk("cmd_valid", cmd_valid, g >= 0);
        if (g >= 0) begin
            chk("cmd_ch", cmd_ch, g);
            chk("cmd_addr", cmd_addr, qa[g][qh[g]]);
            chk("cmd_len", cmd_len, qn[g][qh[g]]);
            chk("cmd_write", cmd_write, m_wr[g]);
        end
        @(posedge clk);
        if (rst_n) begin
            for (int c = 0; c < N; c++) m_done[c] = 0;
            for (int c = 0; c < N; c++) begin
                if (m_drain[c] && (m_wr[c] ? wr_empty : rd_empty)) begin
                    m_drain[c] = 0;
                    m_done[c] = 1;
                end
            end
            if (g >= 0) begin
                if (cmd_ready) begin
                    qh[g]++;
                    if (!pend(g)) m_drain[g] = 1;
                    m_ptr = (g + 1) % N;
                    m_hold = 0;
                end else begin
                    m_hold = 1;
                    m_hold_ch = g;
                end
            end
            for (int c = 0; c < N; c++) begin
                if (!eb[c] && desc_valid[c])
                    load(c, desc_addr[c*AW +: AW], int'(desc_len[c*LW +: LW]), desc_write[c]);
            end
        end
        @(negedge clk);
    endtask

    task automatic set_desc(input int c, input logic [31:0] a, input int len, input bit w);
        desc_addr[c*AW +: AW] = a;
        desc_len[c*LW +: LW]  = 32'(len);
        desc_write[c]         = w;
        desc_valid[c]         = 1'b1;
    endtask

    task automatic put(input int c, input logic [31:0] a, input int len, input bit w);
        set_desc(c, a, len, w);
        step();
        desc_valid = '0;
    endtask

    logic [31:0] ra;
    int          rl;

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        desc_valid = '0;
        desc_write = '0;
        desc_len = '0;
        desc_addr = '0;
        cmd_ready = 1'b0;
        rd_empty = 1'b1;
        wr_empty = 1'b1;
        m_reset();
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        step();

        // long read split into bursts, drain waits for rd_empty
        cmd_ready = 1'b1;
        rd_empty = 1'b0;
        put(0, 32'h0000_1000, 130, 1'b0);
        repeat (5) step();
        rd_empty = 1'b1;
        repeat (3) step();

        // write straddling a 4KB page
        put(1, 32'h0000_0FF0, 10, 1'b1);
        repeat (5) step();

        // round robin over 0,1,3 then 2 joins
        set_desc(0, 32'h0001_0000, 200, 1'b0);
        set_desc(1, 32'h0002_0000, 200, 1'b1);
        set_desc(3, 32'h0003_0000, 200, 1'b0);
        step();
        desc_valid = '0;
        repeat (4) step();
        put(2, 32'h0004_0000, 200, 1'b1);
        repeat (2) step();

        // stall: payload and grant frozen
        cmd_ready = 1'b0;
        repeat (5) step();
        cmd_ready = 1'b1;
        repeat (30) step();

        // zero-length descriptor
        put(2, 32'h0000_2000, 0, 1'b0);
        repeat (2) step();

        // reset in the middle of ISSUE
        put(0, 32'h0000_3000, 200, 1'b0);
        repeat (2) step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();

        // random traffic
        repeat (3000) begin
            for (int c = 0; c < N; c++) begin
                case ($urandom_range(0, 3))
                    0: ra = $urandom & 32'hFFFF_FFFC;
                    1: ra = ($urandom & 32'hFFFF_F000) | 32'h0000_0F80 | (32'($urandom_range(0, 31)) << 2);
                    2: ra = 32'hFFFF_FF00;
                    default: ra = 32'h0000_1000;
                endcase
                case ($urandom_range(0, 3))
                    0: rl = 0;
                    1: rl = $urandom_range(1, 10);
                    2: rl = $urandom_range(60, 140);
                    default: rl = $urandom_range(1, 300);
                endcase
                desc_addr[c*AW +: AW] = ra;
                desc_len[c*LW +: LW]  = 32'(rl);
                desc_write[c] = $urandom_range(0, 1) == 1;
                desc_valid[c] = $urandom_range(0, 7) == 0;
            end
            cmd_ready = $urandom_range(0, 3) != 0;
            rd_empty = $urandom_range(0, 2) != 0;
            wr_empty = $urandom_range(0, 2) != 0;
            rst_n = $urandom_range(0, 499) != 0;
            step();
        end

        desc_valid = '0;
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        rd_empty = 1'b1;
        wr_empty = 1'b1;
        repeat (100) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
